// File: rtl/led_scan_ctrl.sv
// led_scan_ctrl
// Time-multiplexed scan controller for a multi-digit 7-segment display.
// It holds one 5-bit code {dp, hex[3:0]} per digit position. Each digit gets
// one slot: BLANK_CYCLES of blanking, then SHOW_CYCLES lit. During the lit
// part, the digit's code goes to the shared segment decoder and its
// active-low common line is pulled low.
//
// Ports:
//   i_clk, i_rst_n     clock; asynchronous active-low reset
//   i_wr_en            write strobe for the digit buffer
//   i_wr_addr          digit position to write (0 = rightmost)
//   i_wr_data          digit code {dp, hex}
//   i_dig_en           per-digit enable; a disabled digit keeps its slot but stays dark
//   o_dig_ctrl         code presented to the segment decoder
//   o_dec_en           decoder enable (active-high)
//   o_dig_com          active-low digit commons (at most one low)
//   o_cur_idx          index of the current slot
//   o_frame_tick       one-cycle pulse after the last digit's SHOW of each frame
// All outputs are registered, so no input reaches an output combinationally.
module led_scan_ctrl #(
  parameter int NUM_DIGITS   = 8,
  parameter int SHOW_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int AW           = $clog2(NUM_DIGITS)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_wr_en,
  input  logic [AW-1:0]         i_wr_addr,
  input  logic [4:0]            i_wr_data,
  input  logic [NUM_DIGITS-1:0] i_dig_en,
  output logic [4:0]            o_dig_ctrl,
  output logic                  o_dec_en,
  output logic [NUM_DIGITS-1:0] o_dig_com,
  output logic [AW-1:0]         o_cur_idx,
  output logic                  o_frame_tick
);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;

  // The counter must reach the longer of the two state lengths minus one.
  localparam int CNT_MAX = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_CYCLES - 1);
  localparam logic [AW-1:0] IDX_LAST   = AW'(NUM_DIGITS - 1);

  logic [0:0]            state_q,    state_d;
  logic [CW-1:0]         cnt_q,      cnt_d;
  logic [AW-1:0]         idx_q,      idx_d;
  logic [4:0]            dig_buf_q [NUM_DIGITS];
  logic [4:0]            dig_buf_d [NUM_DIGITS];
  logic [4:0]            dig_ctrl_q, dig_ctrl_d;
  logic                  dec_en_q,   dec_en_d;
  logic [NUM_DIGITS-1:0] dig_com_q,  dig_com_d;
  logic                  tick_q,     tick_d;
  logic                  wr_addr_ok;

  // Out-of-range positions exist only when NUM_DIGITS is not a power of two.
  assign wr_addr_ok = ({{(32-AW){1'b0}}, i_wr_addr} < 32'(NUM_DIGITS));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    dig_buf_d  = dig_buf_q;
    dig_ctrl_d = dig_ctrl_q;
    dec_en_d   = dec_en_q;
    dig_com_d  = dig_com_q;
    tick_d     = 1'b0;

    // The FSM reads dig_buf_q below, so a write on the capture edge shows
    // the old code; the new one appears in that digit's next slot.
    if (i_wr_en && wr_addr_ok) begin
      dig_buf_d[i_wr_addr] = i_wr_data;
    end

    case (state_q)
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d    = ST_SHOW;
          cnt_d      = '0;
          dig_ctrl_d = dig_buf_q[idx_q];
          dec_en_d   = 1'b1;
          // A disabled digit still gets its slot and decoder enable, but its
          // common stays high so it remains dark.
          if (i_dig_en[idx_q]) begin
            dig_com_d = ~(NUM_DIGITS'(1) << idx_q);
          end else begin
            dig_com_d = '1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        if (cnt_q == SHOW_LAST) begin
          state_d   = ST_BLANK;
          cnt_d     = '0;
          dig_com_d = '1;
          dec_en_d  = 1'b0;
          if (idx_q == IDX_LAST) begin
            idx_d  = '0;
            tick_d = 1'b1;
          end else begin
            idx_d = idx_q + AW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_BLANK;
      cnt_q      <= '0;
      idx_q      <= '0;
      dig_ctrl_q <= '0;
      dec_en_q   <= 1'b0;
      dig_com_q  <= '1;
      tick_q     <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        dig_buf_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      dig_ctrl_q <= dig_ctrl_d;
      dec_en_q   <= dec_en_d;
      dig_com_q  <= dig_com_d;
      tick_q     <= tick_d;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        dig_buf_q[i] <= dig_buf_d[i];
      end
    end
  end

  assign o_dig_ctrl   = dig_ctrl_q;
  assign o_dec_en     = dec_en_q;
  assign o_dig_com    = dig_com_q;
  assign o_cur_idx    = idx_q;
  assign o_frame_tick = tick_q;

endmodule

// File: doc/led_scan_ctrl.md
Name: led_scan_ctrl

Overview:
Time-multiplexed scan controller for the board's multi-digit 7-segment display.
- Holds one 5-bit digit code per position: bit 4 is the decimal point, bits 3:0 are the hex value.
- Feeds the 5-bit code to the shared segment decoder one digit at a time and drives the active-low digit common-select lines in step.
- Inserts a blanking gap between digits to suppress ghosting.
- Sits between the host logic (counters, FSM status) and the single shared decoder instance.

Parameters:
- NUM_DIGITS, 8, number of digit positions scanned (2..8).
- SHOW_CYCLES, 50000, clock cycles each digit is lit per slot (>=1).
- BLANK_CYCLES, 500, clock cycles of blanking before each digit is lit (>=1).
- AW, $clog2(NUM_DIGITS), width of the digit index and write address.

Ports:
- i_clk  in  1  system clock; the only clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_wr_en  in  1  write strobe for the digit buffer.
- i_wr_addr  in  AW  digit position to write; 0 is the rightmost digit.
- i_wr_data  in  5  digit code {dp, hex[3:0]}.
- i_dig_en  in  NUM_DIGITS  per-digit enable mask; a disabled digit keeps its time slot but stays dark.
- o_dig_ctrl  out  5  code presented to the segment decoder.
- o_dec_en  out  1  decoder enable, active-high; wired to the decoder's i_rst_n so the decoder outputs all-dark when low.
- o_dig_com  out  NUM_DIGITS  digit common selects, active-low; at most one bit low at any time.
- o_cur_idx  out  AW  index of the current slot.
- o_frame_tick  out  1  one-cycle pulse at the end of each full scan frame.

Behaviour:
- Reset (async assert, all outputs registered):
  - digit buffer all 5'h00; state BLANK; index 0; counter 0.
  - o_dig_ctrl=0, o_dec_en=0, o_dig_com all ones, o_cur_idx=0, o_frame_tick=0.
- FSM states:
  - BLANK: all commons high, o_dec_en=0; lasts BLANK_CYCLES cycles.
  - SHOW: the selected digit is lit; lasts SHOW_CYCLES cycles.
  - Cycle counter counts 0..N-1 within each state, then clears on the state change.
- BLANK to SHOW edge:
  - o_dig_ctrl <= buf[idx].
  - o_dec_en <= 1.
  - o_dig_com <= ~(1<<idx) if i_dig_en[idx], else all ones. i_dig_en is sampled only at this edge.
- SHOW to BLANK edge:
  - o_dig_com <= all ones; o_dec_en <= 0.
  - idx <= (idx==NUM_DIGITS-1) ? 0 : idx+1.
  - o_frame_tick=1 for exactly this cycle when idx wraps from NUM_DIGITS-1 to 0.
- Timing:
  - Slot period = BLANK_CYCLES+SHOW_CYCLES.
  - Frame = NUM_DIGITS slots.
  - After reset deassertion, the first SHOW outputs appear at the BLANK_CYCLES-th rising edge.
- Digit buffer writes:
  - Take effect at the next edge.
  - i_wr_addr >= NUM_DIGITS is ignored.
  - A write to the digit currently in SHOW does not change o_dig_ctrl; the new value is shown in that digit's next slot.
  - A write in the same cycle as that digit's BLANK to SHOW edge: the old value is displayed.
- o_dig_ctrl holds its last value during BLANK; only o_dec_en and o_dig_com blank the display.
- Reset asserted mid-SHOW: commons go all high immediately (async). Scanning restarts at index 0 with buffer cleared.
- No combinational path from any input to any output.

Test Plan:
Bench parameters for all scenarios: NUM_DIGITS=4, SHOW=4, BLANK=2, i_dig_en=4'hF unless stated.
1. Reset, then release -> o_dig_com=4'hF and o_dec_en=0 for 2 cycles; then o_dig_com=4'hE, o_dig_ctrl=5'h00, o_dec_en=1 for 4 cycles; then 2 cycles at 4'hF; then 4'hD.
2. Write addr0..3 = 5'h01, 5'h12, 5'h0A, 5'h1F; run one frame -> the slots show codes 01, 12, 0A, 1F with commons E, D, B, 7; o_frame_tick pulses once, on the cycle after digit 3's SHOW ends; frame length is 24 cycles.
3. Write addr1=5'h05 during digit 1's SHOW -> o_dig_ctrl stays at the old value for that slot; the next frame's slot 1 shows 5'h05.
4. i_dig_en=4'b1011 -> during the slot with o_cur_idx=2, o_dig_com=4'hF and o_dec_en=1 with the slot timing unchanged; the other digits light normally.
5. Assert i_rst_n low in the middle of digit 2's SHOW -> o_dig_com=4'hF and o_dec_en=0 without waiting for a clock edge; after release, the scan restarts at idx 0 showing 5'h00.
6. Write with i_wr_addr=... (not applicable at AW=2); instead, over 1000 random cycles check that o_dig_com is never two-hot, and that o_dec_en=0 whenever o_dig_com is all ones within a BLANK state.
